// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
//   state_t     : FSM state encoding (also exported on state_o)
//   OP_* / FN_* : opcode and funct field constants
//   ALU_*       : ALUControl codes
//   alu_op_t    : request from the FSM to the ALU decoder
//   ctrl_t      : per-state datapath control word
//   state_ctrl  : control word a state drives while it is current
// Optional feature macro: GPIO_IN_EN (enables the GPIN state's Ori output).
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEX   = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11,
      GPIN     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_GPIN  = 6'h3F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // AOP_NONE parks ALUControl at 000 in states that do not use the ALU.
   typedef enum logic [1:0] {
      AOP_ADD   = 2'b00,
      AOP_SUB   = 2'b01,
      AOP_FUNCT = 2'b10,
      AOP_NONE  = 2'b11
   } alu_op_t;

   typedef struct packed {
      logic       pc_write;   // unconditional PC enable
      logic       branch;     // PC enable gated by zero
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       memto_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic       pc_src;
      logic       jump;
      logic       ori;
      logic [1:0] alu_src_b;
      alu_op_t    alu_op;
   } ctrl_t;

   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c        = '0;
      c.alu_op = AOP_NONE;
      case (s)
         FETCH: begin
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
            c.alu_src_b = 2'b01;
            c.alu_op    = AOP_ADD;
         end
         DECODE: begin
            c.alu_src_b = 2'b11;
            c.alu_op    = AOP_ADD;
         end
         MEMADR, ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_op    = AOP_ADD;
         end
         MEMREAD:  c.iord = 1'b1;
         MEMWB: begin
            c.memto_reg = 1'b1;
            c.reg_write = 1'b1;
         end
         MEMWRITE: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         EXECUTE: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = AOP_FUNCT;
         end
         ALUWB: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = AOP_SUB;
            c.pc_src    = 1'b1;
            c.branch    = 1'b1;
         end
         ADDIWB:   c.reg_write = 1'b1;
         JUMP: begin
            c.jump     = 1'b1;
            c.pc_write = 1'b1;
         end
`ifdef GPIO_IN_EN
         GPIN: begin
            c.ori       = 1'b1;
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_op    = AOP_ADD;
         end
`endif
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// alu_decoder: combinational ALU control decode.
//   alu_op        : in  2, ADD / SUB / use funct / idle
//   Funct         : in  6, instruction funct field
//   ALUControl    : out 3, ALU operation select
//   funct_illegal : out 1, funct unsupported while alu_op requests funct decode
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [5:0] Funct,
   output logic [2:0] ALUControl,
   output logic       funct_illegal
);

   always_comb begin
      ALUControl    = ALU_ADD;
      funct_illegal = 1'b0;
      case (alu_op)
         AOP_ADD:  ALUControl = ALU_ADD;
         AOP_SUB:  ALUControl = ALU_SUB;
         AOP_FUNCT: begin
            case (Funct)
               FN_ADD:  ALUControl = ALU_ADD;
               FN_SUB:  ALUControl = ALU_SUB;
               FN_AND:  ALUControl = ALU_AND;
               FN_OR:   ALUControl = ALU_OR;
               FN_SLT:  ALUControl = ALU_SLT;
               default: funct_illegal = 1'b1;
            endcase
         end
         default:  ALUControl = ALU_AND;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the multicycle MIPS datapath.
//   clk, reset (async, active-high)   : clocking
//   op, Funct                         : instruction fields from the IR
//   zero_i                            : ALU zero flag, resolves beq
//   PCen ... Ori, ALUSrcB, ALUControl : datapath enables and selects
//   state_o                           : current state (debug)
//   illegal_o                         : unsupported opcode (DECODE) or funct (EXECUTE)
// Optional feature macro: GPIO_IN_EN adds opcode 0x3F -> GPIN.
//
// state    | meaning
// FETCH    | IR <- mem[PC], PC <- PC+4
// DECODE   | branch target computed, dispatch on op
// MEMADR   | address = rs + sext(imm)
// MEMREAD  | data read from memory
// MEMWB    | rt <- loaded data
// MEMWRITE | mem[addr] <- rt
// EXECUTE  | R-type ALU operation
// ALUWB    | rd <- ALU result
// BRANCH   | compare rs/rt, PC <- target on zero
// ADDIEX   | rs + sext(imm)
// ADDIWB   | rt <- ALU result
// JUMP     | PC <- jump target
// GPIN     | rs + sext(GPIO_i) (GPIO_IN_EN builds only)
module multicycle_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] Funct,
   input  logic       zero_i,
   output logic       PCen,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic       PCsrc,
   output logic       Jump,
   output logic       Ori,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [3:0] state_o,
   output logic       illegal_o
);

   // WIDTH documents the datapath this controller drives; no port scales with it.
   if (WIDTH != 32) begin : g_nonstd_width
   end

   state_t state, state_nxt;
   ctrl_t  ctrl_q;
   logic   dec_illegal;
   logic   funct_illegal;

   alu_decoder u_alu_decoder (
      .alu_op        (ctrl_q.alu_op),
      .Funct         (Funct),
      .ALUControl    (ALUControl),
      .funct_illegal (funct_illegal)
   );

   always_comb begin
      state_nxt   = FETCH;
      dec_illegal = 1'b0;
      case (state)
         FETCH:    state_nxt = DECODE;
         DECODE: begin
            case (op)
               OP_RTYPE:     state_nxt = EXECUTE;
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_BEQ:       state_nxt = BRANCH;
               OP_ADDI:      state_nxt = ADDIEX;
               OP_J:         state_nxt = JUMP;
`ifdef GPIO_IN_EN
               OP_GPIN:      state_nxt = GPIN;
`endif
               default:      dec_illegal = 1'b1;
            endcase
         end
         MEMADR:   state_nxt = (op == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  state_nxt = MEMWB;
         EXECUTE:  state_nxt = funct_illegal ? FETCH : ALUWB;
         ADDIEX:   state_nxt = ADDIWB;
`ifdef GPIO_IN_EN
         GPIN:     state_nxt = ADDIWB;
`endif
         default:  state_nxt = FETCH;
      endcase
   end

   // The control word is registered alongside the state so every output is
   // a flop; reset loads the FETCH word, which also kills any pending write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= FETCH;
         ctrl_q <= state_ctrl(FETCH);
      end else begin
         state  <= state_nxt;
         ctrl_q <= state_ctrl(state_nxt);
      end
   end

   assign PCen      = ctrl_q.pc_write | (ctrl_q.branch & zero_i);
   assign IorD      = ctrl_q.iord;
   assign MemWrite  = ctrl_q.mem_write;
   assign IRWrite   = ctrl_q.ir_write;
   assign RegDst    = ctrl_q.reg_dst;
   assign MemtoReg  = ctrl_q.memto_reg;
   assign RegWrite  = ctrl_q.reg_write;
   assign ALUSrcA   = ctrl_q.alu_src_a;
   assign PCsrc     = ctrl_q.pc_src;
   assign Jump      = ctrl_q.jump;
   assign Ori       = ctrl_q.ori;
   assign ALUSrcB   = ctrl_q.alu_src_b;
   assign state_o   = state;
   assign illegal_o = ((state == DECODE) & dec_illegal) |
                      ((state == EXECUTE) & funct_illegal);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Outputs are packed into one
// vector {PCen,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
// PCsrc,Jump,Ori,ALUSrcB,ALUControl,state_o,illegal_o} and compared per
// cycle against hand-written per-state constants.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] Funct;
   logic       zero_i;
   logic       PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
   logic       ALUSrcA, PCsrc, Jump, Ori, illegal_o;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [3:0] state_o;

   int n_checks = 0;
   int n_pass   = 0;

   multicycle_control_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .op(op), .Funct(Funct), .zero_i(zero_i),
      .PCen(PCen), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .PCsrc(PCsrc), .Jump(Jump), .Ori(Ori),
      .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .state_o(state_o),
      .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   logic [20:0] dut_vec;
   assign dut_vec = {PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                     ALUSrcA, PCsrc, Jump, Ori, ALUSrcB, ALUControl, state_o,
                     illegal_o};

   //                                 P I M W R M R A P J O SB  ALU STATE I
   localparam logic [20:0] E_FETCH   = 21'b1_0_0_1_0_0_0_0_0_0_0_01_010_0000_0;
   localparam logic [20:0] E_DECODE  = 21'b0_0_0_0_0_0_0_0_0_0_0_11_010_0001_0;
   localparam logic [20:0] E_DEC_ILL = 21'b0_0_0_0_0_0_0_0_0_0_0_11_010_0001_1;
   localparam logic [20:0] E_MEMADR  = 21'b0_0_0_0_0_0_0_1_0_0_0_10_010_0010_0;
   localparam logic [20:0] E_MEMREAD = 21'b0_1_0_0_0_0_0_0_0_0_0_00_000_0011_0;
   localparam logic [20:0] E_MEMWB   = 21'b0_0_0_0_0_1_1_0_0_0_0_00_000_0100_0;
   localparam logic [20:0] E_MEMWR   = 21'b0_1_1_0_0_0_0_0_0_0_0_00_000_0101_0;
   localparam logic [20:0] E_EX_SUB  = 21'b0_0_0_0_0_0_0_1_0_0_0_00_110_0110_0;
   localparam logic [20:0] E_EX_OR   = 21'b0_0_0_0_0_0_0_1_0_0_0_00_001_0110_0;
   localparam logic [20:0] E_EX_ILL  = 21'b0_0_0_0_0_0_0_1_0_0_0_00_010_0110_1;
   localparam logic [20:0] E_ALUWB   = 21'b0_0_0_0_1_0_1_0_0_0_0_00_000_0111_0;
   localparam logic [20:0] E_BR_Z1   = 21'b1_0_0_0_0_0_0_1_1_0_0_00_110_1000_0;
   localparam logic [20:0] E_BR_Z0   = 21'b0_0_0_0_0_0_0_1_1_0_0_00_110_1000_0;
   localparam logic [20:0] E_ADDIEX  = 21'b0_0_0_0_0_0_0_1_0_0_0_10_010_1001_0;
   localparam logic [20:0] E_ADDIWB  = 21'b0_0_0_0_0_0_1_0_0_0_0_00_000_1010_0;
   localparam logic [20:0] E_JUMP    = 21'b1_0_0_0_0_0_0_0_0_1_0_00_000_1011_0;
   localparam logic [20:0] E_GPIN    = 21'b0_0_0_0_0_0_0_1_0_0_1_10_010_1100_0;

   task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%b want=%b", tag, got, exp);
   endtask

   // Entered on a negedge with the DUT in FETCH; leaves on the negedge after
   // the last listed cycle.
   task automatic run_seq(input string tag, input logic [5:0] o, input logic [5:0] f,
                          input logic z, input int n, input logic [20:0] seq [6]);
      op     = o;
      Funct  = f;
      zero_i = z;
      for (int i = 0; i < n; i++) begin
         #1 chk($sformatf("%s c%0d", tag, i + 1), dut_vec, seq[i]);
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b1;
      op     = 6'h00;
      Funct  = 6'h00;
      zero_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 chk("reset outputs", dut_vec, E_FETCH);
      op    = 6'h23;
      reset = 1'b0;

      run_seq("lw", 6'h23, 6'h00, 1'b0, 5,
              '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, 21'd0});
      run_seq("rsub", 6'h00, 6'h22, 1'b0, 4,
              '{E_FETCH, E_DECODE, E_EX_SUB, E_ALUWB, 21'd0, 21'd0});
      run_seq("ror", 6'h00, 6'h25, 1'b0, 4,
              '{E_FETCH, E_DECODE, E_EX_OR, E_ALUWB, 21'd0, 21'd0});
      run_seq("beq z1", 6'h04, 6'h00, 1'b1, 3,
              '{E_FETCH, E_DECODE, E_BR_Z1, 21'd0, 21'd0, 21'd0});
      run_seq("beq z0", 6'h04, 6'h00, 1'b0, 3,
              '{E_FETCH, E_DECODE, E_BR_Z0, 21'd0, 21'd0, 21'd0});
      run_seq("j", 6'h02, 6'h00, 1'b0, 3,
              '{E_FETCH, E_DECODE, E_JUMP, 21'd0, 21'd0, 21'd0});
`ifdef GPIO_IN_EN
      run_seq("gpin", 6'h3F, 6'h00, 1'b0, 4,
              '{E_FETCH, E_DECODE, E_GPIN, E_ADDIWB, 21'd0, 21'd0});
`else
      run_seq("op3f", 6'h3F, 6'h00, 1'b0, 2,
              '{E_FETCH, E_DEC_ILL, 21'd0, 21'd0, 21'd0, 21'd0});
`endif
      run_seq("bad funct", 6'h00, 6'h00, 1'b0, 3,
              '{E_FETCH, E_DECODE, E_EX_ILL, 21'd0, 21'd0, 21'd0});
      run_seq("addi", 6'h08, 6'h00, 1'b0, 4,
              '{E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB, 21'd0, 21'd0});
      run_seq("sw", 6'h2B, 6'h00, 1'b0, 3,
              '{E_FETCH, E_DECODE, E_MEMADR, 21'd0, 21'd0, 21'd0});
      #1 chk("sw memwrite", dut_vec, E_MEMWR);
      #1 reset = 1'b1;
      #1 chk("sw reset async", dut_vec, E_FETCH);
      @(posedge clk);
      #1 chk("sw reset held", dut_vec, E_FETCH);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("after reset fetch", dut_vec, E_FETCH);
      @(negedge clk);
      #1 chk("after reset decode", dut_vec, E_DECODE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
